// File: rtl/imm_pkg.sv
// Shared constants for the pipelined immediate generator: format codes,
// RV base opcodes used by the auto-select decoder, and skid buffer states.
// Optional feature macro: IMM_GEN_ZIMM_EN (CSR zimm format).
package imm_pkg;

   // Format codes, shared by imm_sel and imm_fmt
   localparam logic [2:0] IMM_I   = 3'd0;
   localparam logic [2:0] IMM_S   = 3'd1;
   localparam logic [2:0] IMM_B   = 3'd2;
   localparam logic [2:0] IMM_U   = 3'd3;
   localparam logic [2:0] IMM_J   = 3'd4;
   localparam logic [2:0] IMM_Z   = 3'd5;
   // Code reported when the opcode decoder finds no immediate format
   localparam logic [2:0] IMM_BAD = 3'd7;

   // Opcodes recognised by the auto-select decoder
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction bits + format code ->
// sign-extended XLEN immediate, echoed format code and illegal flag.
// Optional feature macro: IMM_GEN_ZIMM_EN (format 5 yields zero-extended zimm).
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     inst,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt_out,
   output logic            illegal
);

   logic w_s;

   assign w_s     = inst[31];
   assign fmt_out = fmt;

   // Field scatter/gather per format; illegal formats produce a zero immediate
   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (fmt)
         IMM_I: imm = {{(XLEN-11){w_s}}, inst[30:20]};
         IMM_S: imm = {{(XLEN-11){w_s}}, inst[30:25], inst[11:7]};
         IMM_B: imm = {{(XLEN-12){w_s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U: imm = {{(XLEN-31){w_s}}, inst[30:12], 12'b0};
         IMM_J: imm = {{(XLEN-20){w_s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
         IMM_Z: imm = {{(XLEN-5){1'b0}}, inst[19:15]};
`else
         IMM_Z: illegal = 1'b1;
`endif
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: format select (from imm_sel or decoded
// from the opcode), extraction, and a registered 2-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and in_ready depends only on the
// registered buffer state (no combinational path from out_ready).
// Optional feature macro: IMM_GEN_ZIMM_EN (CSR zimm format / SYSTEM opcode).
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter bit SEL_FROM_OPCODE = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_out,
   output logic [2:0]      imm_fmt,
   output logic            imm_illegal,
   output buf_state_e      dbg_state
);

   buf_state_e r_state;
   buf_state_e w_state_nxt;

   logic [2:0]      w_op_fmt;
   logic [2:0]      w_fmt;
   logic [XLEN-1:0] w_ext_imm;
   logic [2:0]      w_ext_fmt;
   logic            w_ext_ill;

   logic            w_push;
   logic            w_pop;
   logic            w_ld_head_in;
   logic            w_ld_head_tail;
   logic            w_ld_tail;

   logic [XLEN-1:0] r_head_imm;
   logic [2:0]      r_head_fmt;
   logic            r_head_ill;
   logic [XLEN-1:0] r_tail_imm;
   logic [2:0]      r_tail_fmt;
   logic            r_tail_ill;

   // Opcode to format decode used when the format is not supplied externally
   always_comb begin
      w_op_fmt = IMM_BAD;
      case (inst[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: w_op_fmt = IMM_I;
         OP_STORE:                           w_op_fmt = IMM_S;
         OP_BRANCH:                          w_op_fmt = IMM_B;
         OP_LUI, OP_AUIPC:                   w_op_fmt = IMM_U;
         OP_JAL:                             w_op_fmt = IMM_J;
`ifdef IMM_GEN_ZIMM_EN
         OP_SYSTEM:                          w_op_fmt = IMM_Z;
`else
         OP_SYSTEM:                          w_op_fmt = IMM_I;
`endif
         default:                            w_op_fmt = IMM_BAD;
      endcase
   end

   assign w_fmt = SEL_FROM_OPCODE ? w_op_fmt : imm_sel;

   imm_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .inst    (inst[31:7]),
      .fmt     (w_fmt),
      .imm     (w_ext_imm),
      .fmt_out (w_ext_fmt),
      .illegal (w_ext_ill)
   );

   assign in_ready  = (r_state != BUF_FULL);
   assign out_valid = (r_state != BUF_EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign dbg_state = r_state;

   // Buffer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BUF_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Next state and entry-load strobes
   always_comb begin
      w_state_nxt    = r_state;
      w_ld_head_in   = 1'b0;
      w_ld_head_tail = 1'b0;
      w_ld_tail      = 1'b0;
      case (r_state)
         BUF_EMPTY: begin
            if (w_push) begin
               w_state_nxt  = BUF_ONE;
               w_ld_head_in = 1'b1;
            end
         end
         BUF_ONE: begin
            if (w_push && w_pop) begin
               w_ld_head_in = 1'b1;
            end else if (w_push) begin
               w_state_nxt = BUF_FULL;
               w_ld_tail   = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (w_pop) begin
               w_state_nxt    = BUF_ONE;
               w_ld_head_tail = 1'b1;
            end
         end
         default: w_state_nxt = BUF_EMPTY;
      endcase
   end

   // Head/tail entry storage; head is what the consumer sees
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_imm <= '0;
         r_head_fmt <= '0;
         r_head_ill <= 1'b0;
         r_tail_imm <= '0;
         r_tail_fmt <= '0;
         r_tail_ill <= 1'b0;
      end else begin
         if (w_ld_head_in) begin
            r_head_imm <= w_ext_imm;
            r_head_fmt <= w_ext_fmt;
            r_head_ill <= w_ext_ill;
         end else if (w_ld_head_tail) begin
            r_head_imm <= r_tail_imm;
            r_head_fmt <= r_tail_fmt;
            r_head_ill <= r_tail_ill;
         end
         if (w_ld_tail) begin
            r_tail_imm <= w_ext_imm;
            r_tail_fmt <= w_ext_fmt;
            r_tail_ill <= w_ext_ill;
         end
      end
   end

   assign imm_out     = r_head_imm;
   assign imm_fmt     = r_head_fmt;
   assign imm_illegal = r_head_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances share the input stream,
// u_dut_a (XLEN=64, format from imm_sel) and u_dut_b (XLEN=32, format from
// the opcode). Expected results come from an arithmetic reference model.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0;
   logic [31:0] inst = '0;
   logic [2:0]  imm_sel = '0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, ill_a;
   logic [63:0] imm_a;
   logic [2:0]  fmt_a;
   buf_state_e  dbg_a;

   logic        in_ready_b, out_valid_b, ill_b;
   logic [31:0] imm_b;
   logic [2:0]  fmt_b;
   buf_state_e  dbg_b;

   imm_gen_pipe #(.XLEN(64), .SEL_FROM_OPCODE(1'b0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid_a), .out_ready(out_ready),
      .imm_out(imm_a), .imm_fmt(fmt_a), .imm_illegal(ill_a), .dbg_state(dbg_a));

   imm_gen_pipe #(.XLEN(32), .SEL_FROM_OPCODE(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid_b), .out_ready(out_ready),
      .imm_out(imm_b), .imm_fmt(fmt_b), .imm_illegal(ill_b), .dbg_state(dbg_b));

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [67:0] exp_a[$];
   logic [67:0] exp_b[$];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Reference model: {imm[63:0], fmt[2:0], illegal}
   function automatic logic [67:0] model(input logic [31:0] ins, input logic [2:0] sel,
                                         input bit from_op, input int xlen);
      logic [2:0]  f;
      bit          ill;
      bit          zimm_en;
      longint      u;
      longint      v;
      logic [63:0] imm;
`ifdef IMM_GEN_ZIMM_EN
      zimm_en = 1'b1;
`else
      zimm_en = 1'b0;
`endif
      u = longint'({32'b0, ins});
      if (from_op) begin
         case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h1B: f = 3'd0;
            7'h23:                      f = 3'd1;
            7'h63:                      f = 3'd2;
            7'h37, 7'h17:               f = 3'd3;
            7'h6F:                      f = 3'd4;
            7'h73:                      f = zimm_en ? 3'd5 : 3'd0;
            default:                    f = 3'd7;
         endcase
      end else begin
         f = sel;
      end
      ill = (f >= 3'd6) || (f == 3'd5 && !zimm_en);
      v = 0;
      case (f)
         3'd0: v = ((u >> 20) & 2047) - (ins[31] ? 2048 : 0);
         3'd1: v = ((u >> 25) & 63) * 32 + ((u >> 7) & 31) - (ins[31] ? 2048 : 0);
         3'd2: v = ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2
                   - (ins[31] ? 4096 : 0);
         3'd3: v = (u & 64'hFFFF_F000) - (ins[31] ? (longint'(1) << 32) : 0);
         3'd4: v = ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2
                   - (ins[31] ? (longint'(1) << 20) : 0);
         3'd5: v = (u >> 15) & 31;
         default: v = 0;
      endcase
      imm = ill ? 64'd0 : 64'(v);
      if (xlen == 32) imm[63:32] = 32'd0;
      return {imm, f, ill};
   endfunction

   // ---------------- monitor ----------------
   bit          stall_a = 0, stall_b = 0;
   logic [67:0] held_a, held_b, cur_a, cur_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_a = 0;
         stall_b = 0;
      end else begin
         cur_a = {imm_a, fmt_a, ill_a};
         cur_b = {32'd0, imm_b, fmt_b, ill_b};
         if (stall_a) chk("hold_a", {3'b0, out_valid_a, cur_a}, {4'b0001, held_a});
         if (stall_b) chk("hold_b", {3'b0, out_valid_b, cur_b}, {4'b0001, held_b});
         if (out_valid_a && out_ready) begin
            if (exp_a.size() == 0) begin
               total++; bad++;
               $display("FAIL out_a_extra act=%h exp=none", cur_a);
            end else chk("out_a", {4'b0, cur_a}, {4'b0, exp_a.pop_front()});
         end
         if (out_valid_b && out_ready) begin
            if (exp_b.size() == 0) begin
               total++; bad++;
               $display("FAIL out_b_extra act=%h exp=none", cur_b);
            end else chk("out_b", {4'b0, cur_b}, {4'b0, exp_b.pop_front()});
         end
         stall_a = out_valid_a && !out_ready;
         stall_b = out_valid_b && !out_ready;
         held_a  = cur_a;
         held_b  = cur_b;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic send(input logic [31:0] ins, input logic [2:0] sel);
      int waitc = 0;
      inst     = ins;
      imm_sel  = sel;
      in_valid = 1'b1;
      while (!(in_ready_a && in_ready_b) && waitc < 50) begin
         @(posedge clk); #2;
         waitc++;
      end
      if (waitc >= 50) begin
         total++; bad++;
         $display("FAIL send_timeout act=stalled exp=accepted inst=%h", ins);
         in_valid = 1'b0;
      end else begin
         exp_a.push_back(model(ins, sel, 1'b0, 64));
         exp_b.push_back(model(ins, sel, 1'b1, 32));
         @(posedge clk); #2;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int w = 0;
      out_ready = 1'b1;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && w < 200) begin
         @(posedge clk); #2;
         w++;
      end
      repeat (3) begin @(posedge clk); #2; end
      chk("drain_left", 72'(exp_a.size() + exp_b.size()), 72'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_vld_a"}, 72'(out_valid_a), 72'd0);
      chk({tag, "_rdy_a"}, 72'(in_ready_a), 72'd1);
      chk({tag, "_out_a"}, 72'({imm_a, fmt_a, ill_a}), 72'd0);
      chk({tag, "_st_a"},  72'(dbg_a), 72'(BUF_EMPTY));
      chk({tag, "_vld_b"}, 72'(out_valid_b), 72'd0);
      chk({tag, "_rdy_b"}, 72'(in_ready_b), 72'd1);
      chk({tag, "_out_b"}, 72'({imm_b, fmt_b, ill_b}), 72'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};
   bit rnd_done = 0;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk_idle("reset");
      rst_n = 1'b1;
      @(posedge clk); #2;

      // directed vectors, back-to-back with the consumer always ready
      out_ready = 1'b1;
      send(32'hFFF0_0093, 3'd0);
      chk("latency_a", 72'(out_valid_a), 72'd1);
      chk("latency_b", 72'(out_valid_b), 72'd1);
      send(32'hFE20_AE23, 3'd1);
      send(32'hFE00_0CE3, 3'd2);
      send(32'h1234_50B7, 3'd3);
      send(32'h8000_00B7, 3'd3);
      send(32'h0010_00EF, 3'd4);
      send(32'h1234_5013, 3'd7);
      send(32'h0000_007F, 3'd0);
      send(32'h000F_D073, 3'd5);
      drain();

      // back-pressure: A and B fill the buffer, C waits for a pop
      out_ready = 1'b0;
      send(32'h8765_4023, 3'd1);
      send(32'hABCD_E063, 3'd2);
      chk("full_rdy_a", 72'(in_ready_a), 72'd0);
      chk("full_st_a",  72'(dbg_a), 72'(BUF_FULL));
      fork
         send(32'h7FF0_006F, 3'd4);
         begin
            repeat (3) begin @(posedge clk); #2; end
            out_ready = 1'b1;
         end
      join
      drain();

      // randomized traffic with random consumer stalls
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               logic [31:0] r_ins;
               r_ins = $urandom;
               if ($urandom_range(0, 3) != 0) r_ins[6:0] = ops[$urandom_range(0, 10)];
               send(r_ins, 3'($urandom_range(0, 7)));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #2;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      // reset while FULL discards both entries
      out_ready = 1'b0;
      send(32'h0010_0093, 3'd0);
      send(32'hFFFF_F0B7, 3'd3);
      chk("pre_rst_st", 72'(dbg_a), 72'(BUF_FULL));
      rst_n = 1'b0;
      #1;
      chk_idle("midrst");
      exp_a.delete();
      exp_b.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(32'h8000_0EE3, 3'd2);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
